tamagotchi_btn_cond: RTL

TAMAGOTCHI_BTN_COND -- requirements
Module: tamagotchi_btn_cond

---
 rtl/tamagotchi_btn_cond.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tamagotchi_btn_cond.sv
// ---------------------------------------------------------------------------
// tamagotchi_btn_cond: sync, debounce, pulse-stretch and long-press detection for the
// six push keys; optional auto-repeat on action keys with BTN_AUTOREPEAT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tamagotchi_btn_cond #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 250000000,
  parameter int STRETCH_CYCLES    = 5000000,
  parameter int REPEAT_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_salud_n,
  input  logic key_energia_n,
  input  logic key_hambre_n,
  input  logic key_diversion_n,
  input  logic key_reset_n,
  input  logic key_test_n,
  output logic btn_salud,
  output logic btn_energia,
  output logic btn_hambre,
  output logic btn_diversion,
  output logic btn_reset,
  output logic btn_test,
  output logic hold_active
);

  localparam int NKEYS = 6;
  localparam int NACT  = 4;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int ST_W  = $clog2(STRETCH_CYCLES + 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam int RP_W  = $clog2(REPEAT_CYCLES + 1);
`endif

  typedef enum logic [1:0] {
    LP_IDLE    = 2'd0,
    LP_HOLDING = 2'd1,
    LP_FIRED   = 2'd2
  } lp_state_t;

  logic [NKEYS-1:0] w_raw_n;
  logic [NKEYS-1:0] w_deb;
  logic [NKEYS-1:0] w_trig;
  logic [NKEYS-1:0] w_retrig;
  logic [NKEYS-1:0] w_out;
  logic [1:0]       w_fire;
  logic [1:0]       w_holding;
  logic [1:0]       w_lp_start;

  assign w_raw_n = {key_test_n, key_reset_n, key_diversion_n,
                    key_hambre_n, key_energia_n, key_salud_n};

  // Synchronizer and debouncer, one per key; released level is 1.
  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d = w_raw_n[k];
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d = ~deb_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        deb_q   <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
      end
    end

    assign w_deb[k] = deb_q;
  end

  // Action keys: registered press edge, plus optional repeat timer.
  for (genvar k = 0; k < NACT; k++) begin : g_act
    logic deb_prev_q, deb_prev_d;
    logic press_q, press_d;

    always_comb begin
      deb_prev_d = w_deb[k];
      press_d    = deb_prev_q & ~w_deb[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_prev_q <= 1'b1;
        press_q    <= 1'b0;
      end else begin
        deb_prev_q <= deb_prev_d;
        press_q    <= press_d;
      end
    end

    assign w_trig[k] = press_q;

`ifdef BTN_AUTOREPEAT_EN
    // Counts cycles since the last pulse start; zero means no pulse issued this press.
    logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
    logic            rep;

    always_comb begin
      rep      = ~w_deb[k] && (rp_cnt_q == RP_W'(REPEAT_CYCLES));
      rp_cnt_d = rp_cnt_q;
      if (w_deb[k]) begin
        rp_cnt_d = '0;
      end else if (rep || (press_q && !w_out[k])) begin
        rp_cnt_d = RP_W'(1);
      end else if ((rp_cnt_q != '0) && (rp_cnt_q < RP_W'(REPEAT_CYCLES))) begin
        rp_cnt_d = rp_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rp_cnt_q <= '0;
      end else begin
        rp_cnt_q <= rp_cnt_d;
      end
    end

    assign w_retrig[k] = rep;
`else
    assign w_retrig[k] = 1'b0;
`endif
  end

  // Long-press FSMs for the reset (j=0) and test (j=1) keys.
  for (genvar j = 0; j < 2; j++) begin : g_lp
    lp_state_t       state_q, state_d;
    logic [LP_W-1:0] hcnt_q, hcnt_d;
    logic            fire;

    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      fire    = 1'b0;
      case (state_q)
        LP_IDLE: begin
          if (!w_deb[NACT + j]) begin
            state_d = LP_HOLDING;
            hcnt_d  = '0;
          end
        end
        LP_HOLDING: begin
          if (w_deb[NACT + j]) begin
            state_d = LP_IDLE;
            hcnt_d  = '0;
          end else if (hcnt_q == LP_W'(LONG_PRESS_CYCLES - 1)) begin
            state_d = LP_FIRED;
            hcnt_d  = LP_W'(LONG_PRESS_CYCLES);
            fire    = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        LP_FIRED: begin
          if (w_deb[NACT + j]) begin
            state_d = LP_IDLE;
            hcnt_d  = '0;
          end
        end
        default: begin
          state_d = LP_IDLE;
          hcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= LP_IDLE;
        hcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
      end
    end

    assign w_fire[j]    = fire;
    assign w_holding[j] = (state_q == LP_HOLDING);
  end

  // Reset command wins; a test firing alongside or during btn_reset is dropped.
  always_comb begin
    w_lp_start[0] = w_fire[0];
    w_lp_start[1] = w_fire[1] & ~w_fire[0] & ~w_out[NACT];
  end

  assign w_trig[NKEYS-1:NACT]   = w_lp_start;
  assign w_retrig[NKEYS-1:NACT] = 2'b00;

  // Pulse stretchers: a trigger only starts an idle channel, a repeat restarts it.
  for (genvar k = 0; k < NKEYS; k++) begin : g_str
    logic            out_q, out_d;
    logic [ST_W-1:0] st_cnt_q, st_cnt_d;

    always_comb begin
      out_d    = out_q;
      st_cnt_d = st_cnt_q;
      if ((w_trig[k] && !out_q) || w_retrig[k]) begin
        out_d    = 1'b1;
        st_cnt_d = ST_W'(1);
      end else if (out_q) begin
        if (st_cnt_q == ST_W'(STRETCH_CYCLES)) begin
          out_d    = 1'b0;
          st_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q    <= 1'b0;
        st_cnt_q <= '0;
      end else begin
        out_q    <= out_d;
        st_cnt_q <= st_cnt_d;
      end
    end

    assign w_out[k] = out_q;
  end

  assign btn_salud     = w_out[0];
  assign btn_energia   = w_out[1];
  assign btn_hambre    = w_out[2];
  assign btn_diversion = w_out[3];
  assign btn_reset     = w_out[4];
  assign btn_test      = w_out[5];
  assign hold_active   = |w_holding;

endmodule

`default_nettype wire
